// File: rtl/cache_meta_nway_pkg.sv
// cache_meta_nway_pkg
//   Shared definitions for the set-associative metadata store:
//   request op encodings, flush FSM state type and a clog2 helper
//   used to size way-index ports.
package cache_meta_nway_pkg;

    localparam logic [1:0] CACHE_OP_LOOKUP     = 2'd0;
    localparam logic [1:0] CACHE_OP_REFILL     = 2'd1;
    localparam logic [1:0] CACHE_OP_MARK_DIRTY = 2'd2;
    localparam logic [1:0] CACHE_OP_INVAL      = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } meta_state_t;

    // Width of a way index; never below 1 so 1-way indices stay legal.
    function automatic int way_bits(input int n);
        int b;
        b = 0;
        while ((1 << b) < n) b++;
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/cache_meta_nway_plru_tree.sv
// cache_meta_nway_plru_tree
//   Combinational tree pseudo-LRU for one set.
//   Node layout is a heap: node 0 is the root, children of node i are
//   2i+1 (left, lower ways) and 2i+2 (right, upper ways). A node bit of
//   0 points the victim search left, 1 points it right.
// Ports
//   cur        in   WAYS-1  current tree bits of the set
//   touch_way  in   WAY_W   way being accessed
//   nxt        out  WAYS-1  tree bits after touching touch_way
//   victim     out  WAY_W   way the current bits select for replacement
module cache_meta_nway_plru_tree
    import cache_meta_nway_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = way_bits(WAYS)
) (
    input  logic [WAYS-2:0]  cur,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAYS-2:0]  nxt,
    output logic [WAY_W-1:0] victim
);

    // Touch: walk from the root along the accessed way's index bits (MSB
    // first) and point each visited node at the other subtree.
    always_comb begin
        int  node;
        logic dir;
        nxt  = cur;
        node = 0;
        dir  = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir       = touch_way[WAY_W-1-lvl];
            nxt[node] = ~dir;
            node      = 2 * node + 1 + int'(dir);
        end
    end

    // Victim: follow node bits from the root; each bit is one index bit.
    always_comb begin
        int  vnode;
        logic b;
        victim = '0;
        vnode  = 0;
        b      = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b                    = cur[vnode];
            victim[WAY_W-1-lvl]  = b;
            vnode                = 2 * vnode + 1 + int'(b);
        end
    end

endmodule

// File: rtl/cache_meta_nway.sv
// cache_meta_nway
//   Set-associative metadata store: per set and way a valid bit, dirty
//   bit and tag, plus tree pseudo-LRU bits per set. One request per
//   cycle (LOOKUP / REFILL / MARK_DIRTY / INVAL). LOOKUP answers one
//   cycle later with hit and victim information. A flush engine clears
//   valid/dirty/plru one set per cycle after reset or on flush_all; the
//   arrays themselves carry no reset so they can map to LUTRAM.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush_all            pulse, start a flush (ignored while busy)
//   busy                 flush engine running
//   req_*                request channel (op, set, tag, way, dirty)
//   rsp_*                registered LOOKUP response, rsp_valid one cycle
//   dbg_state            flush FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on busy and flush_all,
// never on req_valid, so flush_all wins over a same-cycle request and
// that request stays pending. There is no response back-pressure.
module cache_meta_nway
    import cache_meta_nway_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int TAG_WIDTH  = 20,
    parameter  int SETIDX_BIT = 6,
    localparam int WAY_W      = way_bits(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_all,
    output logic                  busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [SETIDX_BIT-1:0] req_set,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    input  logic [WAY_W-1:0]      req_way,
    input  logic                  req_dirty,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_W-1:0]      rsp_way,
    output logic [WAY_W-1:0]      rsp_victim_way,
    output logic                  rsp_victim_valid,
    output logic                  rsp_victim_dirty,
    output logic [TAG_WIDTH-1:0]  rsp_victim_tag,
    output meta_state_t           dbg_state
);

    localparam int SET_NUM = 1 << SETIDX_BIT;

    // Metadata arrays, no reset.
    logic [WAYS-1:0]      valid_q [SET_NUM];
    logic [WAYS-1:0]      dirty_q [SET_NUM];
    logic [TAG_WIDTH-1:0] tag_q   [SET_NUM][WAYS];
    logic [WAYS-2:0]      plru_q  [SET_NUM];

    meta_state_t          state_q;
    logic [SETIDX_BIT-1:0] flush_cnt_q;

    logic                 accept;
    logic                 is_lookup;
    logic [WAYS-1:0]      row_valid;
    logic [WAYS-1:0]      row_dirty;
    logic [TAG_WIDTH-1:0] row_tag [WAYS];
    logic [WAYS-1:0]      match;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic                 any_inv;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     plru_victim;
    logic [WAY_W-1:0]     victim_way;
    logic [WAY_W-1:0]     touch_way;
    logic [WAYS-2:0]      plru_nxt;

    assign busy      = (state_q == ST_FLUSH);
    assign req_ready = !busy && !flush_all;
    assign accept    = req_valid && req_ready;
    assign is_lookup = (req_op == CACHE_OP_LOOKUP);
    assign dbg_state = state_q;

    // Selected row.
    assign row_valid = valid_q[req_set];
    assign row_dirty = dirty_q[req_set];
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            row_tag[w] = tag_q[req_set][w];
        end
    end

    // Tag compare and hit-way encode (match is at most one-hot).
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = row_valid[w] && (row_tag[w] == req_tag);
            if (match[w]) hit_way = WAY_W'(w);
        end
    end
    assign hit = |match;

    // Lowest-index invalid way; scanning downward lets the lowest win.
    always_comb begin
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!row_valid[w]) inv_way = WAY_W'(w);
        end
    end
    assign any_inv    = !(&row_valid);
    assign victim_way = any_inv ? inv_way : plru_victim;

    // LOOKUP touches the hit way; the other ops touch the addressed way.
    assign touch_way = is_lookup ? hit_way : req_way;

    cache_meta_nway_plru_tree #(.WAYS(WAYS)) u_plru (
        .cur       (plru_q[req_set]),
        .touch_way (touch_way),
        .nxt       (plru_nxt),
        .victim    (plru_victim)
    );

    // Array writes. Flush owns the arrays while busy; requests are not
    // accepted then, so the two never collide. Tags are never cleared.
    always_ff @(posedge clk) begin
        if (busy) begin
            valid_q[flush_cnt_q] <= '0;
            dirty_q[flush_cnt_q] <= '0;
            plru_q[flush_cnt_q]  <= '0;
        end else if (accept) begin
            case (req_op)
                CACHE_OP_LOOKUP: begin
                    if (hit) plru_q[req_set] <= plru_nxt;
                end
                CACHE_OP_REFILL: begin
                    valid_q[req_set][req_way] <= 1'b1;
                    dirty_q[req_set][req_way] <= req_dirty;
                    tag_q[req_set][req_way]   <= req_tag;
                    plru_q[req_set]           <= plru_nxt;
                end
                CACHE_OP_MARK_DIRTY: begin
                    dirty_q[req_set][req_way] <= 1'b1;
                    plru_q[req_set]           <= plru_nxt;
                end
                CACHE_OP_INVAL: begin
                    valid_q[req_set][req_way] <= 1'b0;
                    dirty_q[req_set][req_way] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Flush FSM and response registers. Response fields hold between
    // lookups; only rsp_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_FLUSH;
            flush_cnt_q      <= '0;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_victim_way   <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_all) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == SETIDX_BIT'(SET_NUM - 1)) state_q <= ST_IDLE;
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase

            rsp_valid <= accept && is_lookup;
            if (accept && is_lookup) begin
                rsp_hit          <= hit;
                rsp_way          <= hit_way;
                rsp_victim_way   <= victim_way;
                rsp_victim_valid <= row_valid[victim_way];
                rsp_victim_dirty <= row_dirty[victim_way];
                rsp_victim_tag   <= row_tag[victim_way];
            end
        end
    end

    // A tag may live in at most one valid way of a set.
    a_single_match : assert property (@(posedge clk) disable iff (!rst_n)
        (accept && is_lookup) |-> $onehot0(match));

endmodule

// File: tb/tb_cache_meta_nway.sv
// tb_cache_meta_nway
//   Directed bench for cache_meta_nway: a 4-way/20-bit-tag instance and
//   a 2-way/8-bit-tag instance share clock and reset. Expected LOOKUP
//   responses are queued and compared by a response monitor.
module tb_cache_meta_nway;
    import cache_meta_nway_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- 4-way DUT ----------------
    logic        flush_all, busy, req_valid, req_ready, req_dirty;
    logic [1:0]  req_op, req_way;
    logic [5:0]  req_set;
    logic [19:0] req_tag;
    logic        rsp_valid, rsp_hit, rsp_victim_valid, rsp_victim_dirty;
    logic [1:0]  rsp_way, rsp_victim_way;
    logic [19:0] rsp_victim_tag;
    meta_state_t dbg_state;

    cache_meta_nway #(.WAYS(4), .TAG_WIDTH(20), .SETIDX_BIT(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_all(flush_all), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_set(req_set), .req_tag(req_tag), .req_way(req_way),
        .req_dirty(req_dirty), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .rsp_way(rsp_way), .rsp_victim_way(rsp_victim_way),
        .rsp_victim_valid(rsp_victim_valid), .rsp_victim_dirty(rsp_victim_dirty),
        .rsp_victim_tag(rsp_victim_tag), .dbg_state(dbg_state)
    );

    // ---------------- 2-way DUT ----------------
    logic        b_flush_all, b_busy, b_req_valid, b_req_ready, b_req_dirty;
    logic [1:0]  b_req_op;
    logic [0:0]  b_req_way;
    logic [5:0]  b_req_set;
    logic [7:0]  b_req_tag;
    logic        b_rsp_valid, b_rsp_hit, b_rsp_victim_valid, b_rsp_victim_dirty;
    logic [0:0]  b_rsp_way, b_rsp_victim_way;
    logic [7:0]  b_rsp_victim_tag;
    meta_state_t b_dbg_state;

    cache_meta_nway #(.WAYS(2), .TAG_WIDTH(8), .SETIDX_BIT(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush_all(b_flush_all), .busy(b_busy),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_set(b_req_set), .req_tag(b_req_tag), .req_way(b_req_way),
        .req_dirty(b_req_dirty), .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit),
        .rsp_way(b_rsp_way), .rsp_victim_way(b_rsp_victim_way),
        .rsp_victim_valid(b_rsp_victim_valid), .rsp_victim_dirty(b_rsp_victim_dirty),
        .rsp_victim_tag(b_rsp_victim_tag), .dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Packing: {care_tag, hit, way[1:0], vway[1:0], vvalid, vdirty, vtag[19:0]}
    logic [27:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] e;
        string       nm;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".hit"},    {31'd0, rsp_hit},          {31'd0, e[26]});
                check({nm, ".way"},    {30'd0, rsp_way},          {30'd0, e[25:24]});
                check({nm, ".vway"},   {30'd0, rsp_victim_way},   {30'd0, e[23:22]});
                check({nm, ".vvalid"}, {31'd0, rsp_victim_valid}, {31'd0, e[21]});
                check({nm, ".vdirty"}, {31'd0, rsp_victim_dirty}, {31'd0, e[20]});
                if (e[27]) check({nm, ".vtag"}, {12'd0, rsp_victim_tag}, {12'd0, e[19:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge+1.
    task automatic issue(input logic [1:0] op, input logic [5:0] set, input logic [19:0] tag,
                         input logic [1:0] way, input logic dirty);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = set;
        req_tag   = tag;
        req_way   = way;
        req_dirty = dirty;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [5:0] set, input logic [19:0] tag,
                          input logic hit, input logic [1:0] way, input logic [1:0] vway,
                          input logic vvalid, input logic vdirty, input logic [19:0] vtag,
                          input logic care_tag);
        exp_q.push_back({care_tag, hit, way, vway, vvalid, vdirty, vtag});
        name_q.push_back(nm);
        issue(CACHE_OP_LOOKUP, set, tag, 2'd0, 1'b0);
    endtask

    task automatic b_issue(input logic [1:0] op, input logic [7:0] tag, input logic way);
        b_req_valid = 1'b1;
        b_req_op    = op;
        b_req_set   = 6'd3;
        b_req_tag   = tag;
        b_req_way   = way;
        b_req_dirty = 1'b0;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
    endtask

    task automatic b_lookup(input string nm, input logic [7:0] tag, input logic hit,
                            input logic way, input logic vway, input logic [7:0] vtag);
        b_issue(CACHE_OP_LOOKUP, tag, 1'b0);
        check({nm, ".rsp_valid"}, {31'd0, b_rsp_valid}, 32'd1);
        check({nm, ".hit"},       {31'd0, b_rsp_hit},   {31'd0, hit});
        check({nm, ".way"},       {31'd0, b_rsp_way},   {31'd0, way});
        check({nm, ".vway"},      {31'd0, b_rsp_victim_way}, {31'd0, vway});
        check({nm, ".vtag"},      {24'd0, b_rsp_victim_tag}, {24'd0, vtag});
    endtask

    // Counts busy cycles of both instances until both are idle.
    task automatic wait_flush(output int n, output int bn, output logic ready_seen);
        int guard;
        n = 0;
        bn = 0;
        ready_seen = 1'b0;
        guard = 0;
        while ((busy || b_busy) && guard < 200) begin
            if (busy) n++;
            if (b_busy) bn++;
            if (busy && req_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        n_err++;
        summary();
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   n, bn;
        logic rdy;

        rst_n = 1'b0;
        flush_all = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_set = '0;
        req_tag = '0; req_way = '0; req_dirty = 1'b0;
        b_flush_all = 1'b0; b_req_valid = 1'b0; b_req_op = 2'd0; b_req_set = '0;
        b_req_tag = '0; b_req_way = '0; b_req_dirty = 1'b0;

        // Test 1: reset state and post-reset flush length.
        @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},      32'd1);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, {31'd0, ST_FLUSH});
        check("rst_rsp",   {3'd0, rsp_valid, rsp_hit, rsp_way, rsp_victim_way,
                            rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_flush(n, bn, rdy);
        check("t1_busy_cycles",   n,  32'd64);
        check("t1_b_busy_cycles", bn, 32'd64);
        check("t1_ready_low",     {31'd0, rdy}, 32'd0);
        check("t1_ready_after",   {31'd0, req_ready}, 32'd1);
        check("t1_state_idle",    {31'd0, dbg_state}, {31'd0, ST_IDLE});
        lookup("t1_miss", 6'd5, 20'h123, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 20'h0, 1'b0);

        // Test 2: fill set 5, hit and miss.
        issue(CACHE_OP_REFILL, 6'd5, 20'hA, 2'd0, 1'b0);
        issue(CACHE_OP_REFILL, 6'd5, 20'hB, 2'd1, 1'b0);
        issue(CACHE_OP_REFILL, 6'd5, 20'hC, 2'd2, 1'b1);
        issue(CACHE_OP_REFILL, 6'd5, 20'hD, 2'd3, 1'b0);
        lookup("t2_hitC", 6'd5, 20'hC, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 20'hA, 1'b1);
        @(posedge clk);
        #1;
        check("t2_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        check("t2_rsp_hold", {29'd0, rsp_hit, rsp_way}, {29'd0, 1'b1, 2'd2});
        lookup("t2_missE", 6'd5, 20'hE, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 20'hA, 1'b1);

        // Test 3: PLRU ordering.
        lookup("t3_hitA",  6'd5, 20'hA, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 20'hA, 1'b1);
        lookup("t3_hitC",  6'd5, 20'hC, 1'b1, 2'd2, 2'd3, 1'b1, 1'b0, 20'hD, 1'b1);
        lookup("t3_miss1", 6'd5, 20'hE, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 20'hB, 1'b1);
        issue(CACHE_OP_REFILL, 6'd5, 20'hB, 2'd1, 1'b0);
        lookup("t3_hitB",  6'd5, 20'hB, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 20'hD, 1'b1);
        lookup("t3_miss3", 6'd5, 20'hE, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 20'hD, 1'b1);
        // MARK_DIRTY sets dirty and touches the tree.
        issue(CACHE_OP_MARK_DIRTY, 6'd5, 20'h0, 2'd3, 1'b0);
        lookup("t3_hitA2",  6'd5, 20'hA, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 20'hA, 1'b1);
        lookup("t3_miss2d", 6'd5, 20'hE, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 20'hC, 1'b1);
        lookup("t3_hitC2",  6'd5, 20'hC, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 20'hC, 1'b1);
        lookup("t3_hitB2",  6'd5, 20'hB, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 20'hB, 1'b1);
        lookup("t3_miss3d", 6'd5, 20'hE, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1, 20'hD, 1'b1);

        // Test 4: back-to-back refill/lookup, then invalidate.
        issue(CACHE_OP_REFILL, 6'd9, 20'h70, 2'd0, 1'b0);
        issue(CACHE_OP_REFILL, 6'd9, 20'h71, 2'd1, 1'b0);
        issue(CACHE_OP_REFILL, 6'd9, 20'h72, 2'd2, 1'b0);
        issue(CACHE_OP_REFILL, 6'd9, 20'h77, 2'd3, 1'b0);
        lookup("t4_b2b_hit", 6'd9, 20'h77, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 20'h70, 1'b1);
        issue(CACHE_OP_INVAL, 6'd9, 20'h0, 2'd3, 1'b0);
        lookup("t4_inval",   6'd9, 20'h77, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 20'h77, 1'b1);

        // Test 5: flush_all beats a same-cycle request.
        flush_all = 1'b1;
        req_valid = 1'b1; req_op = CACHE_OP_LOOKUP; req_set = 6'd5; req_tag = 20'hA;
        #1;
        check("t5_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        req_valid = 1'b0;
        check("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
        wait_flush(n, bn, rdy);
        check("t5_busy_cycles",   n,  32'd64);
        check("t5_b_busy_cycles", bn, 32'd0);
        check("t5_ready_low_all", {31'd0, rdy}, 32'd0);
        lookup("t5_set5", 6'd5, 20'hA,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 20'hA,  1'b1);
        lookup("t5_set9", 6'd9, 20'h70, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 20'h70, 1'b1);

        // Test 6: reset in the middle of a flush.
        issue(CACHE_OP_REFILL, 6'd1, 20'h55, 2'd2, 1'b1);
        lookup("t6_pre_hit", 6'd1, 20'h55, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 20'h0, 1'b0);
        flush_all = 1'b1;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("t6_mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp", {3'd0, rsp_valid, rsp_hit, rsp_way, rsp_victim_way,
                             rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag}, 32'd0);
        check("t6_rst_state", {31'd0, dbg_state}, {31'd0, ST_FLUSH});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_flush(n, bn, rdy);
        check("t6_busy_cycles",   n,  32'd64);
        check("t6_b_busy_cycles", bn, 32'd64);
        check("t6_ready_low",     {31'd0, rdy}, 32'd0);
        lookup("t6_post_miss", 6'd1, 20'h55, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 20'h0, 1'b0);

        // 2-way instance: single LRU bit alternates the victim.
        b_issue(CACHE_OP_REFILL, 8'h11, 1'b0);
        b_issue(CACHE_OP_REFILL, 8'h22, 1'b1);
        b_lookup("w2_miss0", 8'h33, 1'b0, 1'b0, 1'b0, 8'h11);
        b_lookup("w2_hit0",  8'h11, 1'b1, 1'b0, 1'b0, 8'h11);
        b_lookup("w2_miss1", 8'h33, 1'b0, 1'b0, 1'b1, 8'h22);
        b_lookup("w2_hit1",  8'h22, 1'b1, 1'b1, 1'b1, 8'h22);
        b_lookup("w2_miss2", 8'h33, 1'b0, 1'b0, 1'b0, 8'h11);

        repeat (3) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 32'd0);
        summary();
        $finish;
    end

endmodule
